nibble_serial_add_ctrl: RTL

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit carry-lookahead adder slice, one nibble per cycle, LSB nibble first.
- Registers the slice carry between cycles.
- Exposes valid/ready handshakes on both the operand side and the result side.
- Sits between the datapath controller and the shared 4-bit adder slice.

---
 rtl/nibble_serial_add_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/subtract sequencer driving one shared 4-bit adder slice, LSB nibble first.
// Optional signed saturation of the result is enabled by defining NIBBLE_ADD_SAT_EN.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic [3:0]       slice_x,
  output logic [3:0]       slice_y,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;

  logic [3:0]       a_nib [NIBBLES];
  logic [3:0]       b_nib [NIBBLES];
  logic [WIDTH-1:0] result_next;
  logic             overflow_next;

  // Nibble views of the operands and the result with the current nibble replaced by the slice sum.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
      assign result_next[4*gi +: 4] = (cnt_reg == CW'(gi)) ? slice_sum : result[4*gi +: 4];
    end
  endgenerate

  // b_reg already holds the effective (possibly inverted) operand, so one rule covers add and subtract.
  assign overflow_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (slice_sum[3] != a_reg[WIDTH-1]);

`ifdef NIBBLE_ADD_SAT_EN
  logic [WIDTH-1:0] sat_value;
  assign sat_value = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg != IDLE);
  assign slice_x   = (state_reg == RUN) ? a_nib[cnt_reg] : 4'd0;
  assign slice_y   = (state_reg == RUN) ? b_nib[cnt_reg] : 4'd0;
  assign slice_cin = (state_reg == RUN) ? carry_reg : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          result    <= result_next;
          carry_reg <= slice_cout;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_NIB) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            out_valid <= 1'b1;
            carry_out <= slice_cout;
            overflow  <= overflow_next;
`ifdef NIBBLE_ADD_SAT_EN
            if (overflow_next) result <= sat_value;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
